// File: rtl/pwm_counter.sv
// pwm_counter: prescaled up/down timebase for the PWM output stage.
// period, prescale and direction are captured into shadow registers and only
// change at period boundaries, on a restart, or while the counter is disabled.
module pwm_counter #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             count_reset,
    input  logic [CNT_W-1:0] period,
    input  logic [PSC_W-1:0] prescale,
    input  logic             up_down,
    output logic [CNT_W-1:0] count_val,
    output logic             period_done,
    output logic             dir_active
);

    logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;
    logic [PSC_W-1:0] psc_sh_q, psc_sh_d;
    logic [CNT_W-1:0] per_sh_q, per_sh_d;
    logic             dir_sh_q, dir_sh_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             tick;
    logic             load_sh;

    // Prescaler terminal count; only meaningful while enabled.
    assign tick = (psc_cnt_q == psc_sh_q);

    // Next-state: restart beats everything, then disable, then normal counting.
    always_comb begin
        psc_cnt_d = psc_cnt_q;
        count_d   = count_q;
        done_d    = 1'b0;
        load_sh   = 1'b0;

        if (count_reset) begin
            psc_cnt_d = '0;
            load_sh   = 1'b1;
            count_d   = up_down ? '0 : period;
        end else if (!en) begin
            // Hold the count, restart the prescaler, track inputs continuously.
            psc_cnt_d = '0;
            load_sh   = 1'b1;
        end else if (tick) begin
            psc_cnt_d = '0;
            if (dir_sh_q) begin
                // >= guarantees a wrap before the all-ones value can overflow.
                if (count_q >= per_sh_q) begin
                    count_d = '0;
                    done_d  = 1'b1;
                    load_sh = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    // Reload takes the new period directly, not the old shadow.
                    count_d = period;
                    done_d  = 1'b1;
                    load_sh = 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end else begin
            psc_cnt_d = psc_cnt_q + 1'b1;
        end
    end

    // Shadow register next-state.
    always_comb begin
        per_sh_d = per_sh_q;
        psc_sh_d = psc_sh_q;
        dir_sh_d = dir_sh_q;
        if (load_sh) begin
            per_sh_d = period;
            psc_sh_d = prescale;
            dir_sh_d = up_down;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_cnt_q <= '0;
            psc_sh_q  <= '0;
            per_sh_q  <= '0;
            dir_sh_q  <= 1'b1;
            count_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            psc_cnt_q <= psc_cnt_d;
            psc_sh_q  <= psc_sh_d;
            per_sh_q  <= per_sh_d;
            dir_sh_q  <= dir_sh_d;
            count_q   <= count_d;
            done_q    <= done_d;
        end
    end

    assign count_val   = count_q;
    assign period_done = done_q;
    assign dir_active  = dir_sh_q;

endmodule

// File: tb/tb_pwm_counter.sv
// Directed bench for pwm_counter; expected values are hand-derived.
module tb_pwm_counter;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned PSC_W = 8;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             count_reset;
    logic [CNT_W-1:0] period;
    logic [PSC_W-1:0] prescale;
    logic             up_down;
    logic [CNT_W-1:0] count_val;
    logic             period_done;
    logic             dir_active;

    int vecs;
    int errs;

    pwm_counter #(
        .CNT_W(CNT_W),
        .PSC_W(PSC_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .count_reset(count_reset),
        .period     (period),
        .prescale   (prescale),
        .up_down    (up_down),
        .count_val  (count_val),
        .period_done(period_done),
        .dir_active (dir_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    // Restart the counter while disabled with the given settings.
    task automatic restart(input logic [CNT_W-1:0] p, input logic [PSC_W-1:0] ps,
                           input logic ud);
        en          = 1'b0;
        period      = p;
        prescale    = ps;
        up_down     = ud;
        count_reset = 1'b1;
        step(1);
        count_reset = 1'b0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        en          = 1'b0;
        count_reset = 1'b0;
        period      = 16'd4;
        prescale    = 8'd0;
        up_down     = 1'b1;
        step(2);
        vecs++;
        if (count_val !== 16'd0 || period_done !== 1'b0 || dir_active !== 1'b1) begin
            $display("FAIL reset: cnt=%0d done=%b dir=%b, want 0/0/1",
                     count_val, period_done, dir_active);
            errs++;
        end
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_up_count();
        logic [CNT_W-1:0] exp_c;
        en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            exp_c = CNT_W'(k % 5);
            vecs++;
            if (count_val !== exp_c || period_done !== (exp_c == 0)) begin
                $display("FAIL up_count k=%0d: cnt=%0d done=%b, want %0d/%b",
                         k, count_val, period_done, exp_c, exp_c == 0);
                errs++;
            end
        end
    endtask

    task automatic test_prescale();
        logic [CNT_W-1:0] exp_c;
        restart(16'd3, 8'd2, 1'b1);
        en = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step(1);
            exp_c = CNT_W'((k / 3) % 4);
            vecs++;
            if (count_val !== exp_c || period_done !== (k % 12 == 0)) begin
                $display("FAIL prescale k=%0d: cnt=%0d done=%b, want %0d/%b",
                         k, count_val, period_done, exp_c, k % 12 == 0);
                errs++;
            end
        end
    endtask

    task automatic test_down_count();
        logic [CNT_W-1:0] exp_c;
        restart(16'd3, 8'd0, 1'b0);
        vecs++;
        if (count_val !== 16'd3 || period_done !== 1'b0 || dir_active !== 1'b0) begin
            $display("FAIL down_restart: cnt=%0d done=%b dir=%b, want 3/0/0",
                     count_val, period_done, dir_active);
            errs++;
        end
        en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            exp_c = CNT_W'(3 - (k % 4));
            vecs++;
            if (count_val !== exp_c || period_done !== (k % 4 == 0)) begin
                $display("FAIL down_count k=%0d: cnt=%0d done=%b, want %0d/%b",
                         k, count_val, period_done, exp_c, k % 4 == 0);
                errs++;
            end
        end
    endtask

    task automatic test_shadowing();
        logic [CNT_W-1:0] exp_c [9];
        logic             exp_d [9];
        exp_c = '{16'd6, 16'd7, 16'd8, 16'd9, 16'd0, 16'd1, 16'd2, 16'd0, 16'd1};
        exp_d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        restart(16'd9, 8'd0, 1'b1);
        en = 1'b1;
        step(5);
        vecs++;
        if (count_val !== 16'd5) begin
            $display("FAIL shadow_pre: cnt=%0d, want 5", count_val);
            errs++;
        end
        period = 16'd2;
        for (int k = 0; k < 9; k++) begin
            step(1);
            vecs++;
            if (count_val !== exp_c[k] || period_done !== exp_d[k] || dir_active !== 1'b1) begin
                $display("FAIL shadow k=%0d: cnt=%0d done=%b dir=%b, want %0d/%b/1",
                         k, count_val, period_done, dir_active, exp_c[k], exp_d[k]);
                errs++;
            end
        end
    endtask

    task automatic test_reset_with_tick();
        restart(16'd9, 8'd0, 1'b1);
        en = 1'b1;
        step(7);
        vecs++;
        if (count_val !== 16'd7) begin
            $display("FAIL rst_tick_pre: cnt=%0d, want 7", count_val);
            errs++;
        end
        count_reset = 1'b1;
        step(1);
        count_reset = 1'b0;
        vecs++;
        if (count_val !== 16'd0 || period_done !== 1'b0) begin
            $display("FAIL rst_tick: cnt=%0d done=%b, want 0/0", count_val, period_done);
            errs++;
        end
        step(1);
        vecs++;
        if (count_val !== 16'd1) begin
            $display("FAIL rst_tick_post: cnt=%0d, want 1", count_val);
            errs++;
        end
    endtask

    task automatic test_period_zero();
        restart(16'd0, 8'd1, 1'b1);
        en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            vecs++;
            if (count_val !== 16'd0 || period_done !== (k % 2 == 0)) begin
                $display("FAIL period_zero k=%0d: cnt=%0d done=%b, want 0/%b",
                         k, count_val, period_done, k % 2 == 0);
                errs++;
            end
        end
    endtask

    task automatic test_disable();
        restart(16'd9, 8'd2, 1'b1);
        en = 1'b1;
        step(18);
        vecs++;
        if (count_val !== 16'd6) begin
            $display("FAIL disable_pre: cnt=%0d, want 6", count_val);
            errs++;
        end
        en = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            vecs++;
            if (count_val !== 16'd6 || period_done !== 1'b0) begin
                $display("FAIL disable_hold k=%0d: cnt=%0d done=%b, want 6/0",
                         k, count_val, period_done);
                errs++;
            end
        end
        en = 1'b1;
        step(2);
        vecs++;
        if (count_val !== 16'd6) begin
            $display("FAIL disable_resume2: cnt=%0d, want 6", count_val);
            errs++;
        end
        step(1);
        vecs++;
        if (count_val !== 16'd7) begin
            $display("FAIL disable_resume3: cnt=%0d, want 7", count_val);
            errs++;
        end
    endtask

    task automatic test_async_reset();
        restart(16'd5, 8'd0, 1'b0);
        en = 1'b1;
        step(2);
        vecs++;
        if (count_val !== 16'd3 || dir_active !== 1'b0) begin
            $display("FAIL async_pre: cnt=%0d dir=%b, want 3/0", count_val, dir_active);
            errs++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        vecs++;
        if (count_val !== 16'd0 || period_done !== 1'b0 || dir_active !== 1'b1) begin
            $display("FAIL async_rst: cnt=%0d done=%b dir=%b, want 0/0/1",
                     count_val, period_done, dir_active);
            errs++;
        end
        en       = 1'b0;
        period   = 16'd4;
        prescale = 8'd1;
        up_down  = 1'b1;
        step(1);
        rst_n = 1'b1;
        step(1);
        en = 1'b1;
        step(1);
        vecs++;
        if (count_val !== 16'd0) begin
            $display("FAIL async_resume1: cnt=%0d, want 0", count_val);
            errs++;
        end
        step(1);
        vecs++;
        if (count_val !== 16'd1) begin
            $display("FAIL async_resume2: cnt=%0d, want 1", count_val);
            errs++;
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_up_count();
        test_prescale();
        test_down_count();
        test_shadowing();
        test_reset_with_tick();
        test_period_zero();
        test_disable();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
